operand_loader_3200: RTL and testbench

- Upstream feeder for the 3200-bit carry-select adder stage (addition_3072_128).
- Accepts operand pairs as 128-bit limbs, least-significant limb first, over a valid/ready stream.
- Assembles them into two full-width operand registers and issues a one-cycle start pulse to the adder.
- Holds the operands stable until the adder reports completion, then accepts the next operand pair.

---
 rtl/operand_loader_3200.sv | 132 +++++++++++++
 tb/tb_operand_loader_3200.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader_3200.sv
// Operand loader for the 3200-bit adder stage.
// Collects operand pairs as 128-bit limbs (least-significant first) over a
// valid/ready stream, fires a one-cycle start pulse, then holds the operands
// stable until the adder reports completion.
//
// Handshake: a limb pair transfers on a rising edge where in_valid && in_ready.
// in_ready comes only from the registered state (high in LOAD); the source must
// hold in_a/in_b/in_last stable while in_valid is high and in_ready is low.
module operand_loader_3200 #(
  parameter int Block    = 128,
  parameter int Num_limb = 25,
  parameter int Size_add = Block * Num_limb
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [Block-1:0]    in_a,
  input  logic [Block-1:0]    in_b,
  input  logic                in_last,
  output logic [Size_add-1:0] a,
  output logic [Size_add-1:0] b,
  output logic                en,
  input  logic                add_done,
  output logic                busy,
  output logic                len_err,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [4:0] LastCnt = 5'(Num_limb - 1);

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [Size_add-1:0] a_q, a_d;
  logic [Size_add-1:0] b_q, b_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                len_err_q, len_err_d;

  // Next-state, limb placement and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    en_d      = 1'b0;
    busy_d    = busy_q;
    len_err_d = len_err_q;
    case (state_q)
      ST_LOAD: begin
        busy_d = 1'b0;
        if (in_valid) begin
          for (int k = 0; k < Num_limb; k++) begin
            if (int'(cnt_q) == k) begin
              a_d[k*Block +: Block] = in_a;
              b_d[k*Block +: Block] = in_b;
            end
          end
          if (in_last || (cnt_q == LastCnt)) begin
            // Close the pair; a missing in_last on the final limb is flagged
            // but the pair is still fired.
            state_d = ST_FIRE;
            cnt_d   = 5'd0;
            en_d    = 1'b1;
            busy_d  = 1'b1;
            if (!in_last) len_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_FIRE: begin
        // add_done is deliberately ignored here.
        state_d = ST_WAIT;
        busy_d  = 1'b1;
      end
      ST_WAIT: begin
        busy_d = 1'b1;
        if (add_done) begin
          // Clearing on exit gives zero-extension for short operands.
          state_d = ST_LOAD;
          a_d     = '0;
          b_d     = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = 5'd0;
        a_d     = '0;
        b_d     = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      cnt_q     <= 5'd0;
      a_q       <= '0;
      b_q       <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      len_err_q <= len_err_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign a         = a_q;
  assign b         = b_q;
  assign en        = en_q;
  assign busy      = busy_q;
  assign len_err   = len_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_operand_loader_3200.sv
// Bench for operand_loader_3200: directed limb streams, expected operand
// images queued at issue time and checked by a monitor on each start pulse.
module tb_operand_loader_3200;

  localparam int W  = 3200;
  localparam int BW = 128;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic          in_last;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          en;
  logic          add_done;
  logic          busy;
  logic          len_err;
  logic [1:0]    state_dbg;

  int total;
  int bad;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic         exp_e_q[$];

  logic         en_prev;

  operand_loader_3200 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .a         (a),
    .b         (b),
    .en        (en),
    .add_done  (add_done),
    .busy      (busy),
    .len_err   (len_err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int k = 0; k < W / BW; k++) begin
        if (act[k*BW +: BW] !== exp[k*BW +: BW]) begin
          $display("FAIL %s: limb %0d got %0h expected %0h", name, k,
                   act[k*BW +: BW], exp[k*BW +: BW]);
          break;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the limb is accepted.
  task automatic send(input logic [BW-1:0] la, input logic [BW-1:0] lb, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a     = la;
    in_b     = lb;
    in_last  = last;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_done();
    add_done = 1'b1;
    @(negedge clk);
    add_done = 1'b0;
  endtask

  task automatic push_exp(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ee);
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    exp_e_q.push_back(ee);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      en_prev = 1'b0;
    end else begin
      if (en) begin
        if (en_prev) begin
          total++;
          bad++;
          $display("FAIL en_width: en high %0d consecutive cycles, required 1", 2);
        end
        if (exp_a_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_en: en=1 with no pending operand pair, required en=0");
        end else begin
          logic [W-1:0] ea;
          logic [W-1:0] eb;
          logic         ee;
          ea = exp_a_q.pop_front();
          eb = exp_b_q.pop_front();
          ee = exp_e_q.pop_front();
          chk_w("mon_a", a, ea);
          chk_w("mon_b", b, eb);
          chk("mon_len_err", 64'(len_err), 64'(ee));
          chk("mon_busy", 64'(busy), 64'd1);
          chk("mon_in_ready", 64'(in_ready), 64'd0);
        end
      end
      en_prev = en;
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] ea;
  logic [W-1:0] eb;
  logic [W:0]   sum_act;
  logic [W:0]   sum_exp;
  logic [BW-1:0] ones;

  initial begin
    total    = 0;
    bad      = 0;
    en_prev  = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_last  = 1'b0;
    add_done = 1'b0;
    ones     = '1;
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk_w("rst_a", a, '0);
    chk_w("rst_b", b, '0);
    chk("rst_en", 64'(en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Full 25-limb operand pair, in_last on limb 24
    ea = '0;
    eb = '0;
    sum_exp = '0;
    for (int k = 0; k < 25; k++) begin
      ea[k*BW +: BW] = BW'(k + 1);
      eb[k*BW +: BW] = BW'(16 + k);
      sum_exp[k*BW +: BW] = BW'(17 + 2 * k);
    end
    push_exp(ea, eb, 1'b0);
    for (int k = 0; k < 25; k++) send(BW'(k + 1), BW'(16 + k), k == 24);
    in_valid = 1'b0;
    chk("t1_en_after_last", 64'(en), 64'd1);
    sum_act = {1'b0, a} + {1'b0, b};
    chk_w("t1_sum_lo", sum_act[W-1:0], sum_exp[W-1:0]);
    chk("t1_sum_carry", 64'(sum_act[W]), 64'd0);
    idle(3);
    chk("t1_wait_en_low", 64'(en), 64'd0);
    pulse_done();
    chk("t1_ready_after_done", 64'(in_ready), 64'd1);
    chk("t1_busy_after_done", 64'(busy), 64'd0);
    chk_w("t1_a_cleared", a, '0);

    // Short operand: 3 all-ones limbs, zero-extended
    ea = '0;
    for (int k = 0; k < 3; k++) ea[k*BW +: BW] = ones;
    push_exp(ea, ea, 1'b0);
    for (int k = 0; k < 3; k++) send(ones, ones, k == 2);
    in_valid = 1'b0;
    chk("t2_en", 64'(en), 64'd1);
    idle(2);
    pulse_done();

    // 25 limbs without in_last: fires anyway and sets len_err
    ea = '0;
    eb = '0;
    for (int k = 0; k < 25; k++) begin
      ea[k*BW +: BW] = BW'(32'hA000 + k);
      eb[k*BW +: BW] = BW'(32'hB000 + k);
    end
    push_exp(ea, eb, 1'b1);
    for (int k = 0; k < 25; k++) send(BW'(32'hA000 + k), BW'(32'hB000 + k), 1'b0);
    in_valid = 1'b0;
    chk("t3_en", 64'(en), 64'd1);
    chk("t3_len_err", 64'(len_err), 64'd1);
    idle(1);
    pulse_done();
    chk("t3_len_err_sticky_load", 64'(len_err), 64'd1);
    // Clean transfer afterwards keeps len_err set
    ea = '0;
    eb = '0;
    ea[0 +: BW] = BW'(5);
    ea[BW +: BW] = BW'(6);
    eb[0 +: BW] = BW'(7);
    eb[BW +: BW] = BW'(8);
    push_exp(ea, eb, 1'b1);
    send(BW'(5), BW'(7), 1'b0);
    send(BW'(6), BW'(8), 1'b1);
    in_valid = 1'b0;
    idle(1);
    pulse_done();

    // Continuous in_valid, add_done delayed 10 cycles after en
    ea = '0;
    eb = '0;
    ea[0 +: BW] = BW'(32'h1234);
    eb[0 +: BW] = BW'(32'h5678);
    push_exp(ea, eb, 1'b1);
    send(BW'(32'h1234), BW'(32'h5678), 1'b1);
    in_a    = BW'(32'hDEAD);
    in_b    = BW'(32'hBEEF);
    in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (in_ready !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL t4_ready_in_wait: cycle %0d got %0b expected 0", i, in_ready);
      end
      if (a !== ea || b !== eb) begin
        total++;
        bad++;
        $display("FAIL t4_hold: cycle %0d a/b changed during wait", i);
      end
      @(negedge clk);
    end
    total += 2;
    pulse_done();
    chk("t4_ready_after_done", 64'(in_ready), 64'd1);
    chk_w("t4_a_cleared", a, '0);
    chk_w("t4_b_cleared", b, '0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);

    // add_done during LOAD (idle and mid-load) and during FIRE
    pulse_done();
    chk("t5_ready_idle_done", 64'(in_ready), 64'd1);
    chk("t5_busy_idle_done", 64'(busy), 64'd0);
    ea = '0;
    eb = '0;
    ea[0 +: BW] = BW'(32'h11);
    ea[BW +: BW] = BW'(32'h22);
    eb[0 +: BW] = BW'(32'h33);
    eb[BW +: BW] = BW'(32'h44);
    push_exp(ea, eb, 1'b1);
    send(BW'(32'h11), BW'(32'h33), 1'b0);
    in_valid = 1'b0;
    pulse_done();
    chk("t5_ready_midload_done", 64'(in_ready), 64'd1);
    send(BW'(32'h22), BW'(32'h44), 1'b1);
    in_valid = 1'b0;
    pulse_done();
    chk("t5_fire_done_ignored_busy", 64'(busy), 64'd1);
    chk("t5_fire_done_ignored_ready", 64'(in_ready), 64'd0);
    idle(3);
    chk("t5_still_waiting", 64'(in_ready), 64'd0);
    chk_w("t5_a_held", a, ea);
    pulse_done();

    // Asynchronous reset mid-cycle while waiting on the adder
    push_exp({{(W-BW){1'b0}}, BW'(32'h77)}, {{(W-BW){1'b0}}, BW'(32'h88)}, 1'b1);
    send(BW'(32'h77), BW'(32'h88), 1'b1);
    in_valid = 1'b0;
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    chk_w("t6_a_async", a, '0);
    chk_w("t6_b_async", b, '0);
    chk("t6_en_async", 64'(en), 64'd0);
    chk("t6_busy_async", 64'(busy), 64'd0);
    chk("t6_len_err_async", 64'(len_err), 64'd0);
    chk("t6_ready_async", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_done();
    chk("t6_late_done_ready", 64'(in_ready), 64'd1);
    chk("t6_late_done_busy", 64'(busy), 64'd0);
    ea = '0;
    eb = '0;
    ea[0 +: BW] = BW'(32'hABC);
    eb[0 +: BW] = BW'(32'hDEF);
    push_exp(ea, eb, 1'b0);
    send(BW'(32'hABC), BW'(32'hDEF), 1'b1);
    in_valid = 1'b0;
    idle(1);
    pulse_done();
    idle(2);

    chk("end_queue_empty", 64'(exp_a_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
